// File: rtl/ex_unit_if.sv
// ID/EX operand bundle, MEM/WB forwarding taps and EX/MEM result for the execute stage.
// The pipeline side drives through master; ex_unit consumes through slave.
interface ex_unit_if #(
   parameter int XLEN     = 32,
   parameter int RADDR_W  = 5,
   parameter int ALUSEL_W = 8
);
   logic [ALUSEL_W-1:0] alusel;
   logic [XLEN-1:0]     s1data;
   logic [XLEN-1:0]     s2data;
   logic [RADDR_W-1:0]  rd;
   logic                regwe;
   logic [RADDR_W-1:0]  reg1addr;
   logic                reg1en;
   logic [RADDR_W-1:0]  reg2addr;
   logic                reg2en;
   logic [RADDR_W-1:0]  mem_rd;
   logic                mem_regwe;
   logic [XLEN-1:0]     mem_wdata;
   logic [RADDR_W-1:0]  wb_rd;
   logic                wb_regwe;
   logic [XLEN-1:0]     wb_wdata;
   logic                flush;
   logic [RADDR_W-1:0]  rd_o;
   logic                regwe_o;
   logic [XLEN-1:0]     wdata_o;
   logic                stall_o;

   modport master (
      output alusel, s1data, s2data, rd, regwe, reg1addr, reg1en, reg2addr, reg2en,
      output mem_rd, mem_regwe, mem_wdata, wb_rd, wb_regwe, wb_wdata, flush,
      input  rd_o, regwe_o, wdata_o, stall_o
   );

   modport slave (
      input  alusel, s1data, s2data, rd, regwe, reg1addr, reg1en, reg2addr, reg2en,
      input  mem_rd, mem_regwe, mem_wdata, wb_rd, wb_regwe, wb_wdata, flush,
      output rd_o, regwe_o, wdata_o, stall_o
   );
endinterface

// File: rtl/ex_unit.sv
// Execute stage: operand forwarding, single-cycle ALU and an iterative shift-add
// multiplier / restoring divider that holds the front of the pipeline while it runs.
module ex_unit #(
   parameter int XLEN     = 32,
   parameter int RADDR_W  = 5,
   parameter int ALUSEL_W = 8
) (
   input logic   clk,
   input logic   rst,
   ex_unit_if.slave ex
);
   localparam int CNT_W = $clog2(XLEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   localparam logic [ALUSEL_W-1:0] OP_NOP   = ALUSEL_W'(8'h00);
   localparam logic [ALUSEL_W-1:0] OP_ADD   = ALUSEL_W'(8'h01);
   localparam logic [ALUSEL_W-1:0] OP_SUB   = ALUSEL_W'(8'h02);
   localparam logic [ALUSEL_W-1:0] OP_AND   = ALUSEL_W'(8'h03);
   localparam logic [ALUSEL_W-1:0] OP_OR    = ALUSEL_W'(8'h04);
   localparam logic [ALUSEL_W-1:0] OP_XOR   = ALUSEL_W'(8'h05);
   localparam logic [ALUSEL_W-1:0] OP_SLL   = ALUSEL_W'(8'h06);
   localparam logic [ALUSEL_W-1:0] OP_SRL   = ALUSEL_W'(8'h07);
   localparam logic [ALUSEL_W-1:0] OP_SRA   = ALUSEL_W'(8'h08);
   localparam logic [ALUSEL_W-1:0] OP_SLT   = ALUSEL_W'(8'h09);
   localparam logic [ALUSEL_W-1:0] OP_SLTU  = ALUSEL_W'(8'h0A);
   localparam logic [ALUSEL_W-1:0] OP_MUL   = ALUSEL_W'(8'h10);
   localparam logic [ALUSEL_W-1:0] OP_MULHU = ALUSEL_W'(8'h11);
   localparam logic [ALUSEL_W-1:0] OP_DIV   = ALUSEL_W'(8'h12);
   localparam logic [ALUSEL_W-1:0] OP_DIVU  = ALUSEL_W'(8'h13);
   localparam logic [ALUSEL_W-1:0] OP_REM   = ALUSEL_W'(8'h14);
   localparam logic [ALUSEL_W-1:0] OP_REMU  = ALUSEL_W'(8'h15);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic logic [XLEN-1:0] fwd_operand(
      input logic               en,
      input logic [RADDR_W-1:0] addr,
      input logic [XLEN-1:0]    sdata,
      input logic               mem_we,
      input logic [RADDR_W-1:0] mem_addr,
      input logic [XLEN-1:0]    mem_data,
      input logic               wb_we,
      input logic [RADDR_W-1:0] wb_addr,
      input logic [XLEN-1:0]    wb_data
   );
      logic [XLEN-1:0] res;
      res = sdata;
      if (en && (addr != {RADDR_W{1'b0}})) begin
         if (mem_we && (mem_addr == addr)) begin
            res = mem_data;
         end else if (wb_we && (wb_addr == addr)) begin
            res = wb_data;
         end else begin
            res = sdata;
         end
      end
      return res;
   endfunction

   state_t              state_r, state_nxt_s;
   logic [XLEN-1:0]     op1_s, op2_s, alu_res_s;
   logic                alu_ok_s, is_multi_s, is_signed_s, is_mul_s, dvz_s;
   logic [XLEN-1:0]     a_mag_s, b_mag_s;
   logic                neg_q_s, neg_r_s;
   logic [CNT_W-1:0]    shamt_s;

   logic [ALUSEL_W-1:0] op_r;
   logic                is_mul_r, neg_q_r, neg_r_r, regwe_r;
   logic [RADDR_W-1:0]  rd_r;
   logic [XLEN-1:0]     b_r, acc_hi_r, acc_lo_r;
   logic [CNT_W-1:0]    cnt_r;

   logic [XLEN:0]       mul_sum_s, div_shift_s, div_diff_s;
   logic [XLEN-1:0]     step_hi_s, step_lo_s, mc_res_s;

   logic [RADDR_W-1:0]  out_rd_s, rd_o_r;
   logic                out_we_s, regwe_o_r, stall_s;
   logic [XLEN-1:0]     out_data_s, wdata_o_r;

   assign op1_s = fwd_operand(ex.reg1en, ex.reg1addr, ex.s1data, ex.mem_regwe, ex.mem_rd,
                              ex.mem_wdata, ex.wb_regwe, ex.wb_rd, ex.wb_wdata);
   assign op2_s = fwd_operand(ex.reg2en, ex.reg2addr, ex.s2data, ex.mem_regwe, ex.mem_rd,
                              ex.mem_wdata, ex.wb_regwe, ex.wb_rd, ex.wb_wdata);
   assign shamt_s = op2_s[CNT_W-1:0];

   // Single-cycle ALU result and opcode validity.
   always_comb begin
      alu_res_s = {XLEN{1'b0}};
      alu_ok_s  = 1'b1;
      case (ex.alusel)
         OP_NOP:  alu_res_s = {XLEN{1'b0}};
         OP_ADD:  alu_res_s = op1_s + op2_s;
         OP_SUB:  alu_res_s = op1_s - op2_s;
         OP_AND:  alu_res_s = op1_s & op2_s;
         OP_OR:   alu_res_s = op1_s | op2_s;
         OP_XOR:  alu_res_s = op1_s ^ op2_s;
         OP_SLL:  alu_res_s = op1_s << shamt_s;
         OP_SRL:  alu_res_s = op1_s >> shamt_s;
         OP_SRA:  alu_res_s = $signed(op1_s) >>> shamt_s;
         OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, ($signed(op1_s) < $signed(op2_s))};
         OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, (op1_s < op2_s)};
         default: alu_ok_s  = 1'b0;
      endcase
   end

   // Multi-cycle decode and operand preparation (magnitudes plus sign fix-up flags).
   always_comb begin
      is_multi_s  = 1'b0;
      is_signed_s = 1'b0;
      is_mul_s    = 1'b0;
      case (ex.alusel)
         OP_MUL, OP_MULHU: begin
            is_multi_s = 1'b1;
            is_mul_s   = 1'b1;
         end
         OP_DIVU, OP_REMU: is_multi_s = 1'b1;
         OP_DIV, OP_REM: begin
            is_multi_s  = 1'b1;
            is_signed_s = 1'b1;
         end
         default: is_multi_s = 1'b0;
      endcase
      dvz_s = !is_mul_s && (op2_s == {XLEN{1'b0}});
      // A zero divisor on raw operands yields all-ones quotient and dividend remainder.
      if (is_signed_s && !dvz_s) begin
         a_mag_s = op1_s[XLEN-1] ? -op1_s : op1_s;
         b_mag_s = op2_s[XLEN-1] ? -op2_s : op2_s;
         neg_q_s = op1_s[XLEN-1] ^ op2_s[XLEN-1];
         neg_r_s = op1_s[XLEN-1];
      end else begin
         a_mag_s = op1_s;
         b_mag_s = op2_s;
         neg_q_s = 1'b0;
         neg_r_s = 1'b0;
      end
   end

   // One shift-add or restoring-divide iteration on the held accumulator.
   always_comb begin
      mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, b_r} : {(XLEN+1){1'b0}});
      div_shift_s = {acc_hi_r, acc_lo_r[XLEN-1]};
      div_diff_s  = div_shift_s - {1'b0, b_r};
      if (is_mul_r) begin
         step_hi_s = mul_sum_s[XLEN:1];
         step_lo_s = {mul_sum_s[0], acc_lo_r[XLEN-1:1]};
      end else if (!div_diff_s[XLEN]) begin
         step_hi_s = div_diff_s[XLEN-1:0];
         step_lo_s = {acc_lo_r[XLEN-2:0], 1'b1};
      end else begin
         step_hi_s = div_shift_s[XLEN-1:0];
         step_lo_s = {acc_lo_r[XLEN-2:0], 1'b0};
      end
   end

   // Sign-corrected multi-cycle result selection.
   always_comb begin
      case (op_r)
         OP_MUL:           mc_res_s = acc_lo_r;
         OP_MULHU:         mc_res_s = acc_hi_r;
         OP_DIV, OP_DIVU:  mc_res_s = neg_q_r ? -acc_lo_r : acc_lo_r;
         OP_REM, OP_REMU:  mc_res_s = neg_r_r ? -acc_hi_r : acc_hi_r;
         default:          mc_res_s = {XLEN{1'b0}};
      endcase
   end

   // Next state, stall request and next output-register contents.
   always_comb begin
      state_nxt_s = state_r;
      stall_s     = 1'b0;
      out_rd_s    = {RADDR_W{1'b0}};
      out_we_s    = 1'b0;
      out_data_s  = {XLEN{1'b0}};
      case (state_r)
         ST_IDLE: begin
            if (ex.flush) begin
               state_nxt_s = ST_IDLE;
            end else if (is_multi_s) begin
               state_nxt_s = ST_BUSY;
               stall_s     = 1'b1;
            end else if (alu_ok_s) begin
               out_rd_s   = ex.rd;
               out_we_s   = ex.regwe;
               out_data_s = alu_res_s;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (ex.flush) begin
               state_nxt_s = ST_IDLE;
            end else begin
               stall_s     = 1'b1;
               state_nxt_s = (cnt_r == CNT_LAST) ? ST_DONE : ST_BUSY;
            end
         end
         ST_DONE: begin
            state_nxt_s = ST_IDLE;
            if (ex.flush) begin
               out_we_s = 1'b0;
            end else begin
               out_rd_s   = rd_r;
               out_we_s   = regwe_r;
               out_data_s = mc_res_s;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Iterative datapath: latch operands on acceptance, step while busy.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         op_r     <= {ALUSEL_W{1'b0}};
         is_mul_r <= 1'b0;
         neg_q_r  <= 1'b0;
         neg_r_r  <= 1'b0;
         rd_r     <= {RADDR_W{1'b0}};
         regwe_r  <= 1'b0;
         b_r      <= {XLEN{1'b0}};
         acc_hi_r <= {XLEN{1'b0}};
         acc_lo_r <= {XLEN{1'b0}};
         cnt_r    <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               cnt_r <= {CNT_W{1'b0}};
               if (!ex.flush && is_multi_s) begin
                  op_r     <= ex.alusel;
                  is_mul_r <= is_mul_s;
                  neg_q_r  <= neg_q_s;
                  neg_r_r  <= neg_r_s;
                  rd_r     <= ex.rd;
                  regwe_r  <= ex.regwe;
                  b_r      <= b_mag_s;
                  acc_hi_r <= {XLEN{1'b0}};
                  acc_lo_r <= a_mag_s;
               end
            end
            ST_BUSY: begin
               if (ex.flush) begin
                  cnt_r <= {CNT_W{1'b0}};
               end else begin
                  acc_hi_r <= step_hi_s;
                  acc_lo_r <= step_lo_s;
                  cnt_r    <= cnt_r + CNT_W'(1);
               end
            end
            default: cnt_r <= {CNT_W{1'b0}};
         endcase
      end
   end

   // EX/MEM output register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_o_r    <= {RADDR_W{1'b0}};
         regwe_o_r <= 1'b0;
         wdata_o_r <= {XLEN{1'b0}};
      end else begin
         rd_o_r    <= out_rd_s;
         regwe_o_r <= out_we_s;
         wdata_o_r <= out_data_s;
      end
   end

   assign ex.rd_o    = rd_o_r;
   assign ex.regwe_o = regwe_o_r;
   assign ex.wdata_o = wdata_o_r;
   assign ex.stall_o = rst & stall_s;
endmodule

// File: tb/tb_ex_unit.sv
// Directed bench for ex_unit: stimulus pushes expected writebacks into a queue,
// a forked monitor pops and compares each time the DUT presents regwe_o.
module tb_ex_unit;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ex_unit_if #(.XLEN(32), .RADDR_W(5), .ALUSEL_W(8)) bus();
   ex_unit #(.XLEN(32), .RADDR_W(5), .ALUSEL_W(8)) dut (.clk(clk), .rst(rst), .ex(bus));

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check32(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", nm, got, want);
      end
   endtask

   task automatic idle_inputs();
      bus.alusel = 8'h00; bus.s1data = 32'h0; bus.s2data = 32'h0;
      bus.rd = 5'd0; bus.regwe = 1'b0; bus.flush = 1'b0;
      bus.reg1addr = 5'd0; bus.reg1en = 1'b0; bus.reg2addr = 5'd0; bus.reg2en = 1'b0;
      bus.mem_rd = 5'd0; bus.mem_regwe = 1'b0; bus.mem_wdata = 32'h0;
      bus.wb_rd = 5'd0; bus.wb_regwe = 1'b0; bus.wb_wdata = 32'h0;
   endtask

   // Called just after a rising edge; returns just after the edge that wrote the result.
   task automatic issue(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rdv, input logic [31:0] exp, input string nm,
                        input int exp_stall);
      exp_t e;
      int   stalls = 0;
      int   bad_bubbles = 0;
      bit   done = 1'b0;
      bus.alusel = op; bus.s1data = a; bus.s2data = b; bus.rd = rdv; bus.regwe = 1'b1;
      e.rd = rdv; e.data = exp; e.name = nm;
      exp_q.push_back(e);
      for (int i = 0; i < 100 && !done; i++) begin
         @(negedge clk);
         if (bus.stall_o) begin
            stalls++;
            if (stalls > 1 && bus.regwe_o) bad_bubbles++;
         end else begin
            done = 1'b1;
         end
      end
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout: stall_o still high after 100 cycles, expected release", nm);
      end
      check32({nm, "_stall_cycles"}, stalls, exp_stall);
      if (exp_stall > 0) check32({nm, "_bubbles"}, bad_bubbles, 0);
      @(posedge clk);
      #1;
      bus.alusel = 8'h00;
      bus.regwe  = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      idle_inputs();
      fork
         begin
            exp_t me;
            forever begin
               @(negedge clk);
               if (rst && bus.regwe_o) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL unexpected_write: got rd=%0d data=%h, expected no write",
                              bus.rd_o, bus.wdata_o);
                  end else begin
                     me = exp_q.pop_front();
                     if (bus.rd_o !== me.rd || bus.wdata_o !== me.data) begin
                        failures++;
                        $display("FAIL %s: got rd=%0d data=%h, expected rd=%0d data=%h",
                                 me.name, bus.rd_o, bus.wdata_o, me.rd, me.data);
                     end
                  end
               end
            end
         end
      join_none

      repeat (2) @(negedge clk);
      check32("reset_rd_o", {27'd0, bus.rd_o}, 32'd0);
      check32("reset_regwe_o", {31'd0, bus.regwe_o}, 32'd0);
      check32("reset_wdata_o", bus.wdata_o, 32'd0);
      check32("reset_stall_o", {31'd0, bus.stall_o}, 32'd0);
      @(posedge clk); #1; rst = 1'b1;

      // Forwarding: MEM beats WB, WB used when MEM idle, enables and x0 respected.
      bus.reg1en = 1'b1; bus.reg1addr = 5'd5;
      bus.mem_rd = 5'd5; bus.mem_regwe = 1'b1; bus.mem_wdata = 32'd10;
      bus.wb_rd = 5'd5; bus.wb_regwe = 1'b1; bus.wb_wdata = 32'd20;
      issue(8'h01, 32'd1, 32'd3, 5'd1, 32'd13, "fwd_mem", 0);
      bus.mem_regwe = 1'b0;
      issue(8'h01, 32'd1, 32'd3, 5'd1, 32'd23, "fwd_wb", 0);
      bus.reg1addr = 5'd0; bus.mem_rd = 5'd0; bus.mem_regwe = 1'b1; bus.mem_wdata = 32'hFF;
      issue(8'h01, 32'd0, 32'd4, 5'd1, 32'd4, "fwd_x0", 0);
      bus.reg1en = 1'b0; bus.reg1addr = 5'd7; bus.reg2en = 1'b1; bus.reg2addr = 5'd7;
      bus.mem_rd = 5'd7; bus.mem_wdata = 32'h100;
      issue(8'h02, 32'h11, 32'h0, 5'd2, 32'hFFFFFF11, "fwd_op2_only", 0);
      idle_inputs();

      issue(8'h02, 32'd5, 32'd7, 5'd3, 32'hFFFFFFFE, "sub", 0);
      issue(8'h01, 32'hFFFFFFFF, 32'd2, 5'd3, 32'd1, "add_wrap", 0);
      issue(8'h03, 32'hF0F0F0F0, 32'hFF00FF00, 5'd4, 32'hF000F000, "and", 0);
      issue(8'h04, 32'hF0F0F0F0, 32'h0F0F0000, 5'd4, 32'hFFFFF0F0, "or", 0);
      issue(8'h05, 32'hFFFF0000, 32'h0FF00FF0, 5'd4, 32'hF00F0FF0, "xor", 0);
      issue(8'h06, 32'd1, 32'h3F, 5'd5, 32'h80000000, "sll_mask", 0);
      issue(8'h07, 32'h80000000, 32'h24, 5'd5, 32'h08000000, "srl", 0);
      issue(8'h08, 32'h80000000, 32'd4, 5'd5, 32'hF8000000, "sra", 0);
      issue(8'h09, 32'hFFFFFFFF, 32'd1, 5'd6, 32'd1, "slt", 0);
      issue(8'h0A, 32'hFFFFFFFF, 32'd1, 5'd6, 32'd0, "sltu", 0);
      issue(8'h01, 32'd6, 32'd6, 5'd0, 32'd12, "add_rd0", 0);

      issue(8'h13, 32'd100, 32'd7, 5'd9, 32'd14, "divu", 33);
      issue(8'h15, 32'd100, 32'd7, 5'd9, 32'd2, "remu", 33);
      issue(8'h12, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFD, "div_neg", 33);
      issue(8'h14, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, "rem_neg", 33);
      issue(8'h12, 32'd5, 32'd0, 5'd11, 32'hFFFFFFFF, "div_by0", 33);
      issue(8'h12, 32'hFFFFFFFB, 32'd0, 5'd11, 32'hFFFFFFFF, "div_neg_by0", 33);
      issue(8'h14, 32'hFFFFFFF9, 32'd0, 5'd11, 32'hFFFFFFF9, "rem_by0", 33);
      issue(8'h15, 32'd100, 32'd0, 5'd11, 32'd100, "remu_by0", 33);
      issue(8'h12, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h80000000, "div_ovf", 33);
      issue(8'h14, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'd0, "rem_ovf", 33);
      issue(8'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'd1, "mul", 33);
      issue(8'h11, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13, 32'hFFFFFFFE, "mulhu", 33);
      issue(8'h10, 32'h12345678, 32'h10, 5'd13, 32'h23456780, "mul_small", 33);

      // Unknown opcode: no stall, no write.
      bus.alusel = 8'h20; bus.regwe = 1'b1; bus.rd = 5'd3; bus.s1data = 32'd1; bus.s2data = 32'd2;
      @(posedge clk); @(negedge clk);
      check32("unknown_regwe_o", {31'd0, bus.regwe_o}, 32'd0);
      check32("unknown_stall_o", {31'd0, bus.stall_o}, 32'd0);
      @(posedge clk); #1;
      idle_inputs();

      // Flush part-way through a DIV.
      bus.alusel = 8'h12; bus.s1data = 32'd1000; bus.s2data = 32'd3; bus.rd = 5'd4; bus.regwe = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      check32("busy_stall_o", {31'd0, bus.stall_o}, 32'd1);
      bus.flush = 1'b1; bus.alusel = 8'h00; bus.regwe = 1'b0;
      @(negedge clk);
      check32("flush_stall_same_cycle", {31'd0, bus.stall_o}, 32'd0);
      @(posedge clk); #1; bus.flush = 1'b0;
      @(negedge clk);
      check32("flush_regwe_o", {31'd0, bus.regwe_o}, 32'd0);
      check32("flush_stall_after", {31'd0, bus.stall_o}, 32'd0);
      @(posedge clk); #1;
      issue(8'h01, 32'd2, 32'd3, 5'd8, 32'd5, "add_after_flush", 0);

      // Reset asserted mid-BUSY.
      bus.alusel = 8'h13; bus.s1data = 32'd500; bus.s2data = 32'd9; bus.rd = 5'd14; bus.regwe = 1'b1;
      repeat (6) @(posedge clk);
      #3; rst = 1'b0;
      #1;
      check32("rst_mid_stall_o", {31'd0, bus.stall_o}, 32'd0);
      check32("rst_mid_regwe_o", {31'd0, bus.regwe_o}, 32'd0);
      check32("rst_mid_wdata_o", bus.wdata_o, 32'd0);
      idle_inputs();
      @(posedge clk); #1; rst = 1'b1;
      issue(8'h02, 32'd5, 32'd7, 5'd15, 32'hFFFFFFFE, "sub_after_rst", 0);

      repeat (3) @(negedge clk);
      check32("scoreboard_drain", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
